// File: rtl/spram_rr_arbiter.sv
// Round-robin arbiter sharing one byte-write SPRAM port between NUM_REQ requesters.
// Stalls same-word accesses for one cycle after a write and routes read data back.
module spram_rr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_DEPTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_write_data,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_write_strb,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_read_data,
  output logic                            mem_if_write,
  output logic [ADDR_WIDTH-1:0]           mem_if_address,
  output logic [DATA_WIDTH-1:0]           mem_if_write_data,
  output logic [DATA_WIDTH/8-1:0]         mem_if_write_strb,
  input  logic [DATA_WIDTH-1:0]           mem_if_read_data
);

  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W    = (ADDR_DEPTH > 1) ? $clog2(ADDR_DEPTH) : 1;
  localparam int unsigned PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   last_grant;
  logic               wr_q;
  logic [IDX_W-1:0]   wr_idx_q;
  logic [NUM_REQ-1:0] rsp_owner_q;

  logic [IDX_W-1:0]   word_idx [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_any;
  logic [IDX_W-1:0]   grant_word_idx;

  // Mask every requester touching the word written last cycle
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      word_idx[i] = req_address[i*ADDR_WIDTH + ADDR_LSB +: IDX_W];
      eligible[i] = req_valid[i] && !(wr_q && (word_idx[i] == wr_idx_q));
    end
  end

  // Search from last_grant+1, wrapping; first eligible requester wins
  always_comb begin
    int unsigned      cand;
    logic [PTR_W-1:0] cand_p;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    cand_p    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = 32'(last_grant) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_p = PTR_W'(cand);
      if (!grant_any && !rst && eligible[cand_p]) begin
        grant_any     = 1'b1;
        grant_idx     = cand_p;
        grant[cand_p] = 1'b1;
      end
    end
  end

  always_comb begin
    mem_if_write      = 1'b0;
    mem_if_address    = '0;
    mem_if_write_data = '0;
    mem_if_write_strb = '0;
    grant_word_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        mem_if_write      = req_write[i];
        mem_if_address    = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_if_write_data = req_write_data[i*DATA_WIDTH +: DATA_WIDTH];
        mem_if_write_strb = req_write_strb[i*STRB_W +: STRB_W];
        grant_word_idx    = word_idx[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant  <= PTR_W'(NUM_REQ - 1);
      wr_q        <= 1'b0;
      wr_idx_q    <= '0;
      rsp_owner_q <= '0;
    end else begin
      if (grant_any) begin
        last_grant <= grant_idx;
        wr_idx_q   <= grant_word_idx;
      end
      wr_q        <= mem_if_write;
      rsp_owner_q <= grant & ~req_write;
    end
  end

  assign req_ready     = grant;
  // A read issued just before reset must not surface while reset is held
  assign rsp_valid     = rst ? '0 : rsp_owner_q;
  assign rsp_read_data = mem_if_read_data;

endmodule

// File: tb/tb_spram_rr_arbiter.sv
// Directed bench for spram_rr_arbiter with a behavioural byte-write SPRAM.
// Driver queues per-cycle and read-response expectations; a negedge monitor checks them.
module tb_spram_rr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      req_write;
  logic [N*AW-1:0]   req_address;
  logic [N*DW-1:0]   req_write_data;
  logic [N*SW-1:0]   req_write_strb;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_read_data;
  logic              mem_if_write;
  logic [AW-1:0]     mem_if_address;
  logic [DW-1:0]     mem_if_write_data;
  logic [SW-1:0]     mem_if_write_strb;
  logic [DW-1:0]     mem_if_read_data;

  spram_rr_arbiter #(
    .NUM_REQ(N), .ADDR_DEPTH(32), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_write_data(req_write_data),
    .req_write_strb(req_write_strb),
    .rsp_valid(rsp_valid), .rsp_read_data(rsp_read_data),
    .mem_if_write(mem_if_write), .mem_if_address(mem_if_address),
    .mem_if_write_data(mem_if_write_data), .mem_if_write_strb(mem_if_write_strb),
    .mem_if_read_data(mem_if_read_data)
  );

  always #5 clk = ~clk;

  // Behavioural SPRAM: byte-strobed writes, read data registered one cycle
  logic [DW-1:0] mem [32];
  logic [DW-1:0] rd_q;
  assign mem_if_read_data = rd_q;

  initial begin
    for (int w = 0; w < 32; w++) mem[w] = 32'hC0DE_0000 | 32'(w);
    mem[8] = 32'h1122_3344;
    rd_q   = '0;
  end

  always @(posedge clk) begin
    if (mem_if_write) begin
      for (int b = 0; b < SW; b++)
        if (mem_if_write_strb[b]) mem[mem_if_address[6:2]][8*b +: 8] <= mem_if_write_data[8*b +: 8];
    end else begin
      rd_q <= mem[mem_if_address[6:2]];
    end
  end

  typedef struct {
    logic [N-1:0]  ready;
    logic [N-1:0]  rsp;
    logic          mw;
    logic [AW-1:0] addr;
  } cyc_exp_t;

  typedef struct {
    int            owner;
    logic [DW-1:0] data;
  } rsp_exp_t;

  cyc_exp_t exp_q [$];
  rsp_exp_t rsp_q [$];
  int checks = 0;
  int errors = 0;

  // Monitor: compare per-cycle outputs and any read response against queued expectations
  always @(negedge clk) begin
    cyc_exp_t e;
    rsp_exp_t r;
    logic [N-1:0] oh;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks += 4;
      if (req_ready !== e.ready) begin
        errors++; $display("FAIL req_ready got %b want %b at %0t", req_ready, e.ready, $time);
      end
      if (rsp_valid !== e.rsp) begin
        errors++; $display("FAIL rsp_valid got %b want %b at %0t", rsp_valid, e.rsp, $time);
      end
      if (mem_if_write !== e.mw) begin
        errors++; $display("FAIL mem_if_write got %b want %b at %0t", mem_if_write, e.mw, $time);
      end
      if (mem_if_address !== e.addr) begin
        errors++; $display("FAIL mem_if_address got %h want %h at %0t", mem_if_address, e.addr, $time);
      end
    end
    if (rsp_valid != '0) begin
      checks++;
      if (rsp_q.size() == 0) begin
        errors++; $display("FAIL rsp_unexpected got owner %b data %h at %0t", rsp_valid, rsp_read_data, $time);
      end else begin
        r  = rsp_q.pop_front();
        oh = N'(1) << r.owner;
        if (rsp_valid !== oh || rsp_read_data !== r.data) begin
          errors++;
          $display("FAIL rsp_data got owner %b data %h want owner %b data %h at %0t",
                   rsp_valid, rsp_read_data, oh, r.data, $time);
        end
      end
    end
  end

  task automatic set_req(input int i, input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_valid[i]               = v;
    req_write[i]               = w;
    req_address[i*AW +: AW]    = a;
    req_write_data[i*DW +: DW] = d;
    req_write_strb[i*SW +: SW] = s;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic rd(input int i, input logic [AW-1:0] a);
    set_req(i, 1'b1, 1'b0, a, '0, '0);
  endtask

  task automatic step(input logic [N-1:0] er, input logic [N-1:0] ers, input logic emw,
                      input logic [AW-1:0] ea);
    cyc_exp_t e;
    e.ready = er; e.rsp = ers; e.mw = emw; e.addr = ea;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic exp_rsp(input int o, input logic [DW-1:0] d);
    rsp_exp_t r;
    r.owner = o; r.data = d;
    rsp_q.push_back(r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_all();
    for (int i = 0; i < N; i++) rd(i, AW'(4 * i));
    @(posedge clk);
    #1;
    // Reset held two cycles with every requester valid
    step(4'b0000, 4'b0000, 1'b0, 32'h0);
    step(4'b0000, 4'b0000, 1'b0, 32'h0);
    rst = 1'b0;

    // Fairness rotation over continuous reads
    exp_rsp(0, 32'hC0DE_0000); step(4'b0001, 4'b0000, 1'b0, 32'h0);
    exp_rsp(1, 32'hC0DE_0001); step(4'b0010, 4'b0001, 1'b0, 32'h4);
    exp_rsp(2, 32'hC0DE_0002); step(4'b0100, 4'b0010, 1'b0, 32'h8);
    exp_rsp(3, 32'hC0DE_0003); step(4'b1000, 4'b0100, 1'b0, 32'hC);
    exp_rsp(0, 32'hC0DE_0000); step(4'b0001, 4'b1000, 1'b0, 32'h0);
    clear_all();               step(4'b0000, 4'b0001, 1'b0, 32'h0);

    // Read-after-write hazard on word 0x10
    set_req(0, 1'b1, 1'b1, 32'h10, 32'hAABB_CCDD, 4'b1111);
    step(4'b0001, 4'b0000, 1'b1, 32'h10);
    rd(0, 32'h10); rd(1, 32'h14);
    exp_rsp(1, 32'hC0DE_0005); step(4'b0010, 4'b0000, 1'b0, 32'h14);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    exp_rsp(0, 32'hAABB_CCDD); step(4'b0001, 4'b0010, 1'b0, 32'h10);
    clear_all();               step(4'b0000, 4'b0001, 1'b0, 32'h0);

    // Partial-strobe writes to the same word need a bubble
    set_req(0, 1'b1, 1'b1, 32'h20, 32'h0000_00FF, 4'b0001);
    step(4'b0001, 4'b0000, 1'b1, 32'h20);
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b1, 1'b1, 32'h20, 32'h0000_EE00, 4'b0010);
    step(4'b0000, 4'b0000, 1'b0, 32'h0);
    step(4'b0010, 4'b0000, 1'b1, 32'h20);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    rd(0, 32'h20);
    step(4'b0000, 4'b0000, 1'b0, 32'h0);
    exp_rsp(0, 32'h1122_EEFF); step(4'b0001, 4'b0000, 1'b0, 32'h20);
    clear_all();               step(4'b0000, 4'b0001, 1'b0, 32'h0);

    // Reset right after a read grant drops its response and restarts the pointer
    rd(2, 32'h8);
    step(4'b0100, 4'b0000, 1'b0, 32'h8);
    rst = 1'b1;
    set_req(2, 1'b0, 1'b0, '0, '0, '0);
    rd(0, 32'h0); rd(1, 32'h4);
    step(4'b0000, 4'b0000, 1'b0, 32'h0);
    rst = 1'b0;
    rd(3, 32'hC);
    exp_rsp(0, 32'hC0DE_0000); step(4'b0001, 4'b0000, 1'b0, 32'h0);

    // req2 waits behind continuously valid req0/req1 and is served with its fields intact
    set_req(3, 1'b0, 1'b0, '0, '0, '0);
    rd(2, 32'h8);
    exp_rsp(1, 32'hC0DE_0001); step(4'b0010, 4'b0001, 1'b0, 32'h4);
    exp_rsp(2, 32'hC0DE_0002); step(4'b0100, 4'b0010, 1'b0, 32'h8);
    set_req(2, 1'b0, 1'b0, '0, '0, '0);
    exp_rsp(0, 32'hC0DE_0000); step(4'b0001, 4'b0100, 1'b0, 32'h0);
    clear_all();               step(4'b0000, 4'b0001, 1'b0, 32'h0);
    step(4'b0000, 4'b0000, 1'b0, 32'h0);

    checks += 2;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL cycle_queue got %0d left want 0", exp_q.size());
    end
    if (rsp_q.size() != 0) begin
      errors++; $display("FAIL rsp_queue got %0d responses missing want 0", rsp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spram_rr_arbiter.md
Name: spram_rr_arbiter

Overview:
- Round-robin arbiter sharing one byte_write_spram port between NUM_REQ requesters, e.g. matrix A/B loaders, result writer and host.
- Grants at most one access per cycle and drives the SPRAM mem_if_* port.
- Routes 1-cycle-latency read data back to the issuing requester.
- Stalls accesses that would hit the SPRAM's internal write-commit/read-modify-write hazard.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
ADDR_DEPTH, 32, SPRAM depth in words
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data width, multiple of 8

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester grant/accept (one-hot or zero)
req_write  input  NUM_REQ  1=write, 0=read
req_address  input  NUM_REQ*ADDR_WIDTH  byte addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_write_data  input  NUM_REQ*DATA_WIDTH  write data, packed as above
req_write_strb  input  NUM_REQ*DATA_WIDTH/8  byte strobes, packed as above
rsp_valid  output  NUM_REQ  read data valid, one-hot or zero
rsp_read_data  output  DATA_WIDTH  shared read data bus
mem_if_write  output  1  to SPRAM
mem_if_address  output  ADDR_WIDTH  to SPRAM
mem_if_write_data  output  DATA_WIDTH  to SPRAM
mem_if_write_strb  output  DATA_WIDTH/8  to SPRAM
mem_if_read_data  input  DATA_WIDTH  from SPRAM, valid 1 cycle after address

Behaviour:
- Word index = address[ADDR_LSB +: $clog2(ADDR_DEPTH)], where ADDR_LSB = $clog2(DATA_WIDTH/8).
- Handshake: a transfer occurs when req_valid[i] && req_ready[i]. A requester holds all req_* fields stable while valid && !ready and must not drop valid before ready.
- Grant logic is combinational from req_valid, the hazard mask and registered state. req_ready is the one-hot grant vector.
- mem_if_* is a combinational mux of the granted requester's fields.
  - When no grant: mem_if_write=0, mem_if_write_strb=0, mem_if_address=0, mem_if_write_data=0.
- Round-robin:
  - Registered pointer last_grant, reset value NUM_REQ-1, so requester 0 has first priority.
  - Search starts at last_grant+1 modulo NUM_REQ.
  - Pointer updates only on a grant. Skipped or masked requesters keep their position.
- Hazard tracking:
  - Registers wr_q (a write was granted last cycle) and wr_idx_q (its word index).
  - When wr_q=1, every requester whose word index equals wr_idx_q is masked from arbitration that cycle, for both reads and writes. This prevents reading stale data and lost bytes in partial-strobe read-modify-write.
  - Unmasked requesters may still be granted in that cycle.
  - A masked requester becomes eligible the following cycle; its pointer position is not consumed.
- Read response:
  - A read granted in cycle t sets rsp_valid[i]=1 in cycle t+1 only, with rsp_read_data = mem_if_read_data in cycle t+1.
  - rsp_valid is registered (rsp_owner_q one-hot). rsp_read_data is a combinational pass-through, don't-care when rsp_valid=0.
  - Writes produce no response.
- Throughput: one access per cycle sustained. Back-to-back reads, or writes to different words, incur no bubbles.
- Reset (rst=1 at a rising edge):
  - last_grant<=NUM_REQ-1, wr_q<=0, wr_idx_q<=0, rsp_owner_q<=0.
  - While rst=1: req_ready=0, mem_if_write=0 and all mem_if_* =0.
  - A read granted in the cycle before reset assertion does not produce rsp_valid.
- Simultaneous read grant and response: legal. rsp_valid refers to the previous cycle's read; req_ready refers to the current cycle's.
- Single requester continuously valid with others idle: granted every cycle, except hazard cycles caused by its own consecutive same-word accesses after a write.

Test Plan:
- Reset: assert rst 2 cycles with all req_valid=1 -> req_ready=0000, rsp_valid=0000, mem_if_write=0 throughout. After release, first grant is 0001.
- Fairness: all 4 requesters issue continuous reads to addresses 0x0,0x4,0x8,0xC -> grants 0001,0010,0100,1000,0001 in successive cycles. Each rsp_valid follows its grant by exactly 1 cycle with the word stored at that address.
- Hazard: req0 writes 0xAABBCCDD strb 1111 to addr 0x10; next cycle req0 reads 0x10 and req1 reads 0x14 -> cycle 2 grants req1 only; cycle 3 grants req0. req0 response = 0xAABBCCDD.
- Partial strobes: init word 0x20 = 0x11223344. Back-to-back writes from req0 (0x000000FF, strb 0001) and req1 (0x0000EE00, strb 0010) both to 0x20 -> one bubble cycle inserted between them. Readback = 0x1122EEFF.
- Reset mid-operation: read granted in cycle t, rst=1 in cycle t+1 -> rsp_valid stays 0. After release, the pointer restarts at requester 0.
- Stability: req2 holds a read while req0 and req1 are continuously valid -> req2 granted within 3 cycles. Its fields are sampled unchanged at grant.
